// File: rtl/colorled_pkg.sv
// Shared types and helpers for the colour LED matrix scanner.
package colorled_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam int unsigned DIM_W = 4;

    // Tick counter width able to hold max(a, b) - 1, never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/colorled_frame_buffer.sv
// Pending/active LED map pair; the active map only changes on a frame boundary.
module colorled_frame_buffer
    import colorled_pkg::*;
#(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             boundary,
    output logic [WIDTH-1:0] view
);

    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] active;
    logic             pending_valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pending       <= '0;
            active        <= '0;
            pending_valid <= 1'b0;
        end else if (boundary && load) begin
            active        <= data;
            pending_valid <= 1'b0;
        end else if (boundary && pending_valid) begin
            active        <= pending;
            pending_valid <= 1'b0;
        end else if (load) begin
            pending       <= data;
            pending_valid <= 1'b1;
        end
    end

    // Forward the incoming map during the boundary cycle so a one-tick blank still sees it.
    always_comb begin
        view = active;
        if (boundary) begin
            if (load) begin
                view = data;
            end else if (pending_valid) begin
                view = pending;
            end
        end
    end

endmodule

// File: rtl/colorled_matrix_scanner.sv
// Row-scanned colour LED matrix driver with blanking dead-time and registered outputs.
// Optional global brightness control when COLORLED_GLOBAL_DIM_EN is defined.
module colorled_matrix_scanner
    import colorled_pkg::*;
#(
    parameter  int unsigned ROWS           = 4,
    parameter  int unsigned COLS           = 3,
    parameter  int unsigned BLANK_TICKS    = 16,
    parameter  int unsigned DRIVE_TICKS    = 1000,
    parameter  int unsigned COL_ACTIVE_LOW = 1,
    localparam int unsigned RW             = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 i_enable,
    input  logic [ROWS*COLS-1:0] i_led_data,
    input  logic                 i_load,
`ifdef COLORLED_GLOBAL_DIM_EN
    input  logic [DIM_W-1:0]     i_dim,
`endif
    output logic [ROWS-1:0]      o_row,
    output logic [COLS-1:0]      o_col,
    output logic [RW-1:0]        o_row_idx,
    output logic                 o_frame_start,
    output logic                 o_busy
);

    localparam int unsigned     TW         = cnt_width(BLANK_TICKS, DRIVE_TICKS);
    localparam logic [TW-1:0]   BLANK_LAST = TW'(BLANK_TICKS - 1);
    localparam logic [TW-1:0]   DRIVE_LAST = TW'(DRIVE_TICKS - 1);
    localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
    localparam logic [COLS-1:0] COL_OFF    = (COL_ACTIVE_LOW != 0) ? '1 : '0;

    state_t                state, state_nx;
    logic [TW-1:0]         tick, tick_nx;
    logic [RW-1:0]         row_idx, row_nx;
    logic [ROWS*COLS-1:0]  view;
    logic [COLS-1:0]       slice;
    logic [ROWS-1:0]       row_drive;
    logic                  col_on;

    // o_frame_start marks the cycle on which the buffer swaps in a new map.
    colorled_frame_buffer #(.WIDTH(ROWS*COLS)) u_frame_buffer (
        .clk      (aclk),
        .resetn   (aresetn),
        .load     (i_load),
        .data     (i_led_data),
        .boundary (o_frame_start),
        .view     (view)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state   <= IDLE;
            tick    <= '0;
            row_idx <= '0;
        end else begin
            state   <= state_nx;
            tick    <= tick_nx;
            row_idx <= row_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tick_nx  = tick;
        row_nx   = row_idx;
        unique case (state)
            IDLE: begin
                if (i_enable) begin
                    state_nx = BLANK;
                    tick_nx  = '0;
                    row_nx   = '0;
                end
            end
            BLANK: begin
                if (tick == BLANK_LAST) begin
                    state_nx = DRIVE;
                    tick_nx  = '0;
                end else begin
                    tick_nx = tick + 1'b1;
                end
            end
            DRIVE: begin
                if (tick == DRIVE_LAST) begin
                    tick_nx = '0;
                    // Disable is honoured only here, so a started slot always completes.
                    if (!i_enable) begin
                        state_nx = IDLE;
                        row_nx   = '0;
                    end else begin
                        state_nx = BLANK;
                        row_nx   = (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
                    end
                end else begin
                    tick_nx = tick + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        slice = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (row_idx == RW'(r)) begin
                slice = view[r*COLS +: COLS];
            end
        end
        row_drive = ROWS'(1) << row_idx;
    end

`ifdef COLORLED_GLOBAL_DIM_EN
    logic [31:0] dim_limit;
    assign dim_limit = ((32'(i_dim) + 32'd1) * DRIVE_TICKS) >> DIM_W;
    assign col_on    = (32'(tick) < dim_limit);
`else
    assign col_on = 1'b1;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            o_row         <= '0;
            o_col         <= COL_OFF;
            o_row_idx     <= '0;
            o_frame_start <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_row         <= (state == DRIVE) ? row_drive : '0;
            o_col         <= (state == DRIVE && col_on) ? (slice ^ COL_OFF) : COL_OFF;
            o_row_idx     <= row_idx;
            o_frame_start <= (state == BLANK) && (row_idx == '0) && (tick == '0);
            o_busy        <= (state != IDLE);
        end
    end

endmodule

// File: tb/tb_colorled_matrix_scanner.sv
// Directed self-checking bench for colorled_matrix_scanner (ROWS=4, COLS=3, BLANK=2, DRIVE=8).
module tb_colorled_matrix_scanner;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 3;
    localparam int unsigned BT   = 2;
    localparam int unsigned DT   = 8;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        i_enable;
    logic [11:0] i_led_data;
    logic        i_load;
`ifdef COLORLED_GLOBAL_DIM_EN
    logic [3:0]  i_dim;
`endif
    logic [3:0]  o_row;
    logic [2:0]  o_col;
    logic [1:0]  o_row_idx;
    logic        o_frame_start;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    colorled_matrix_scanner #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .BLANK_TICKS    (BT),
        .DRIVE_TICKS    (DT),
        .COL_ACTIVE_LOW (1)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .i_enable      (i_enable),
        .i_led_data    (i_led_data),
        .i_load        (i_load),
`ifdef COLORLED_GLOBAL_DIM_EN
        .i_dim         (i_dim),
`endif
        .o_row         (o_row),
        .o_col         (o_col),
        .o_row_idx     (o_row_idx),
        .o_frame_start (o_frame_start),
        .o_busy        (o_busy)
    );

    // Frame slot: 10 cycles per row, first 2 blank, then 8 driven.
    function automatic logic [3:0] exp_row(input int k);
        return ((k % 10) >= 2) ? (4'b0001 << ((k / 10) % 4)) : 4'b0000;
    endfunction

    task automatic sync_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (o_frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        aresetn = 1'b0; i_enable = 1'b0; i_load = 1'b0; i_led_data = '0;
`ifdef COLORLED_GLOBAL_DIM_EN
        i_dim = 4'd15;
`endif
        repeat (3) @(negedge aclk);
        checks++; if (o_row !== 4'b0000) begin errors++; $display("FAIL reset_row got=%b exp=%b", o_row, 4'b0000); end
        checks++; if (o_col !== 3'b111) begin errors++; $display("FAIL reset_col got=%b exp=%b", o_col, 3'b111); end
        checks++; if (o_row_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", o_row_idx); end
        checks++; if (o_frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b exp=0", o_frame_start); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        aresetn = 1'b1;
        @(negedge aclk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", o_busy); end
    endtask

    task automatic test_frame_timing;
        int lat;
        i_enable = 1'b1;
        lat = 0;
        do begin
            @(negedge aclk);
            lat++;
        end while (o_frame_start !== 1'b1 && lat < 20);
        checks++; if (lat != 2) begin errors++; $display("FAIL start_latency got=%0d exp=2", lat); end
        for (int k = 0; k < 80; k++) begin
            if (k > 0) @(negedge aclk);
            checks++; if (o_row !== exp_row(k)) begin errors++; $display("FAIL timing_row k=%0d got=%b exp=%b", k, o_row, exp_row(k)); end
            checks++; if (o_frame_start !== (k % 40 == 0)) begin errors++; $display("FAIL timing_fs k=%0d got=%b exp=%b", k, o_frame_start, (k % 40 == 0)); end
            checks++; if (o_row_idx !== 2'((k / 10) % 4)) begin errors++; $display("FAIL timing_idx k=%0d got=%0d exp=%0d", k, o_row_idx, (k / 10) % 4); end
            checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL timing_busy k=%0d got=%b exp=1", k, o_busy); end
            checks++; if (o_col !== 3'b111) begin errors++; $display("FAIL timing_col k=%0d got=%b exp=111", k, o_col); end
        end
    endtask

    task automatic test_column_mapping;
        bit ok;
        logic [2:0] tab [4];
        logic [2:0] ec;
        tab = '{3'b011, 3'b100, 3'b110, 3'b010};
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL colmap_sync got=timeout exp=frame_start"); end
        for (int k = 0; k < 80; k++) begin
            if (k > 0) @(negedge aclk);
            ec = (k < 40 || (k % 10) < 2) ? 3'b111 : tab[(k - 40) / 10];
            checks++; if (o_col !== ec) begin errors++; $display("FAIL colmap_col k=%0d got=%b exp=%b", k, o_col, ec); end
            if (k == 40) begin
                checks++; if (o_frame_start !== 1'b1) begin errors++; $display("FAIL colmap_fs got=%b exp=1", o_frame_start); end
            end
            if (k == 15) begin i_load = 1'b1; i_led_data = 12'hA5C; end
            if (k == 16) i_load = 1'b0;
        end
    endtask

    task automatic test_mid_frame_load;
        bit ok;
        logic [2:0] ec;
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL midload_sync got=timeout exp=frame_start"); end
        // Boundary-cycle load of 000 makes this frame dark; FFF lands mid-frame.
        i_load = 1'b1; i_led_data = 12'h000;
        for (int k = 0; k < 80; k++) begin
            if (k > 0) @(negedge aclk);
            ec = (k < 40 || (k % 10) < 2) ? 3'b111 : 3'b000;
            checks++; if (o_col !== ec) begin errors++; $display("FAIL midload_col k=%0d got=%b exp=%b", k, o_col, ec); end
            if (k == 1) i_load = 1'b0;
            if (k == 15) begin i_load = 1'b1; i_led_data = 12'hFFF; end
            if (k == 16) i_load = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [2:0] tab [3][4];
        logic [2:0] ec;
        tab = '{'{3'b000, 3'b000, 3'b000, 3'b000},
                '{3'b101, 3'b111, 3'b111, 3'b111},
                '{3'b000, 3'b110, 3'b011, 3'b110}};
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_sync got=timeout exp=frame_start"); end
        for (int k = 0; k < 120; k++) begin
            if (k > 0) @(negedge aclk);
            ec = ((k % 10) < 2) ? 3'b111 : tab[k / 40][(k % 40) / 10];
            checks++; if (o_col !== ec) begin errors++; $display("FAIL b2b_col k=%0d got=%b exp=%b", k, o_col, ec); end
            if (k == 12) begin i_load = 1'b1; i_led_data = 12'h001; end
            if (k == 13) i_led_data = 12'h002;
            if (k == 14) i_load = 1'b0;
            if (k == 80) begin i_load = 1'b1; i_led_data = 12'h30F; end
            if (k == 81) i_load = 1'b0;
        end
    endtask

    task automatic test_disable;
        bit ok;
        logic [3:0] er;
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL disable_sync got=timeout exp=frame_start"); end
        for (int k = 0; k < 36; k++) begin
            if (k > 0) @(negedge aclk);
            er = (k < 30) ? exp_row(k) : 4'b0000;
            checks++; if (o_row !== er) begin errors++; $display("FAIL disable_row k=%0d got=%b exp=%b", k, o_row, er); end
            checks++; if (o_busy !== (k < 30)) begin errors++; $display("FAIL disable_busy k=%0d got=%b exp=%b", k, o_busy, (k < 30)); end
            if (k >= 30) begin
                checks++; if (o_col !== 3'b111) begin errors++; $display("FAIL disable_col k=%0d got=%b exp=111", k, o_col); end
                checks++; if (o_frame_start !== 1'b0) begin errors++; $display("FAIL disable_fs k=%0d got=%b exp=0", k, o_frame_start); end
            end
            // Brief drop in row 0 is recovered before the slot ends; the row 2 drop is not.
            if (k == 5) i_enable = 1'b0;
            if (k == 7) i_enable = 1'b1;
            if (k == 24) i_enable = 1'b0;
        end
    endtask

    task automatic test_reset_mid_drive;
        bit ok;
        i_enable = 1'b1;
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_sync got=timeout exp=frame_start"); end
        repeat (5) @(negedge aclk);
        checks++; if (o_row !== 4'b0001) begin errors++; $display("FAIL rstmid_pre_row got=%b exp=0001", o_row); end
        aresetn = 1'b0;
        @(negedge aclk);
        checks++; if (o_row !== 4'b0000) begin errors++; $display("FAIL rstmid_row got=%b exp=0000", o_row); end
        checks++; if (o_col !== 3'b111) begin errors++; $display("FAIL rstmid_col got=%b exp=111", o_col); end
        checks++; if (o_row_idx !== 2'd0) begin errors++; $display("FAIL rstmid_idx got=%0d exp=0", o_row_idx); end
        checks++; if (o_frame_start !== 1'b0) begin errors++; $display("FAIL rstmid_fs got=%b exp=0", o_frame_start); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", o_busy); end
        aresetn = 1'b1;
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_resync got=timeout exp=frame_start"); end
        repeat (5) @(negedge aclk);
        checks++; if (o_row !== 4'b0001) begin errors++; $display("FAIL rstmid_post_row got=%b exp=0001", o_row); end
        checks++; if (o_col !== 3'b111) begin errors++; $display("FAIL rstmid_post_col got=%b exp=111", o_col); end
    endtask

`ifdef COLORLED_GLOBAL_DIM_EN
    task automatic test_dimming;
        bit ok;
        int on_a, on_b;
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL dim_sync got=timeout exp=frame_start"); end
        i_load = 1'b1; i_led_data = 12'hFFF; i_dim = 4'd3;
        on_a = 0; on_b = 0;
        for (int k = 0; k < 50; k++) begin
            if (k > 0) @(negedge aclk);
            if (k >= 2 && k < 10 && o_col !== 3'b111) on_a++;
            if (k >= 42 && k < 50 && o_col !== 3'b111) on_b++;
            if (k == 1) i_load = 1'b0;
            if (k == 39) i_dim = 4'd15;
        end
        checks++; if (on_a != 2) begin errors++; $display("FAIL dim3_on got=%0d exp=2", on_a); end
        checks++; if (on_b != 8) begin errors++; $display("FAIL dim15_on got=%0d exp=8", on_b); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_frame_timing();
        test_column_mapping();
        test_mid_frame_load();
        test_back_to_back();
        test_disable();
        test_reset_mid_drive();
`ifdef COLORLED_GLOBAL_DIM_EN
        test_dimming();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
